// File: rtl/id_pkg.sv
// rtl/id_pkg.sv - opcode/funct constants, buffer entry type and immediate helper
package id_pkg;

   localparam logic [5:0] OP_SPECIAL = 6'h00;
   localparam logic [5:0] OP_REGIMM  = 6'h01;
   localparam logic [5:0] OP_J       = 6'h02;
   localparam logic [5:0] OP_JAL     = 6'h03;
   localparam logic [5:0] OP_BEQ     = 6'h04;
   localparam logic [5:0] OP_BNE     = 6'h05;
   localparam logic [5:0] OP_BLEZ    = 6'h06;
   localparam logic [5:0] OP_BGTZ    = 6'h07;

   localparam logic [5:0] FN_JR      = 6'h08;
   localparam logic [5:0] FN_JALR    = 6'h09;

   localparam logic [4:0] RT_BLTZ    = 5'h00;
   localparam logic [4:0] RT_BGEZ    = 5'h01;
   localparam logic [4:0] RT_BLTZAL  = 5'h10;
   localparam logic [4:0] RT_BGEZAL  = 5'h11;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } ibuf_entry_t;

   function automatic logic [31:0] branch_offset(input logic [31:0] instr);
      return {{14{instr[15]}}, instr[15:0], 2'b00};
   endfunction

endpackage

// File: rtl/id_branch_unit.sv
// rtl/id_branch_unit.sv - combinational branch/jump evaluation on resolved operands
module id_branch_unit
   import id_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [31:0]       instr_i,
   input  logic [31:0]       pc_i,
   input  logic [DATA_W-1:0] rs_val_i,
   input  logic [DATA_W-1:0] rt_val_i,
   output logic              is_ctrl_o,
   output logic              taken_o,
   output logic [31:0]       target_o
);

   logic [5:0]  op;
   logic [4:0]  rt_code;
   logic [5:0]  funct;
   logic [31:0] pc4;
   logic        rs_neg;
   logic        rs_zero;

   assign op      = instr_i[31:26];
   assign rt_code = instr_i[20:16];
   assign funct   = instr_i[5:0];
   assign pc4     = pc_i + 32'd4;
   assign rs_neg  = rs_val_i[DATA_W-1];
   assign rs_zero = (rs_val_i == '0);

   always_comb begin
      is_ctrl_o = 1'b0;
      taken_o   = 1'b0;
      target_o  = pc4 + branch_offset(instr_i);
      case (op)
         OP_BEQ:  begin is_ctrl_o = 1'b1; taken_o = (rs_val_i == rt_val_i); end
         OP_BNE:  begin is_ctrl_o = 1'b1; taken_o = (rs_val_i != rt_val_i); end
         OP_BLEZ: begin is_ctrl_o = 1'b1; taken_o = rs_neg | rs_zero; end
         OP_BGTZ: begin is_ctrl_o = 1'b1; taken_o = !rs_neg && !rs_zero; end
         OP_REGIMM: begin
            case (rt_code)
               RT_BLTZ, RT_BLTZAL: begin is_ctrl_o = 1'b1; taken_o = rs_neg;  end
               RT_BGEZ, RT_BGEZAL: begin is_ctrl_o = 1'b1; taken_o = !rs_neg; end
               default: ;
            endcase
         end
         OP_J, OP_JAL: begin
            is_ctrl_o = 1'b1;
            taken_o   = 1'b1;
            target_o  = {pc4[31:28], instr_i[25:0], 2'b00};
         end
         OP_SPECIAL: begin
            if (funct == FN_JR || funct == FN_JALR) begin
               is_ctrl_o = 1'b1;
               taken_o   = 1'b1;
               target_o  = 32'(rs_val_i);
            end
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/id_issue_buffer.sv
// rtl/id_issue_buffer.sv - DEPTH-entry decode/issue buffer with forwarding, interlock and redirect
// Optional: ID_DELAY_SLOT_EN keeps the delay-slot entry behind a taken branch.
module id_issue_buffer
   import id_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int DEPTH   = 4,
   parameter int NUM_FWD = 3
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      if_valid_i,
   output logic                      if_ready_o,
   input  logic [31:0]               if_instr_i,
   input  logic [31:0]               if_pc_i,
   output logic [4:0]                rf_raddr_a_o,
   output logic [4:0]                rf_raddr_b_o,
   input  logic [DATA_W-1:0]         rf_rdata_a_i,
   input  logic [DATA_W-1:0]         rf_rdata_b_i,
   input  logic                      wb_we_i,
   input  logic [4:0]                wb_addr_i,
   input  logic [DATA_W-1:0]         wb_data_i,
   input  logic [NUM_FWD-1:0]        fwd_valid_i,
   input  logic [NUM_FWD-1:0]        fwd_ready_i,
   input  logic [NUM_FWD*5-1:0]      fwd_addr_i,
   input  logic [NUM_FWD*DATA_W-1:0] fwd_data_i,
   output logic                      ex_valid_o,
   input  logic                      ex_ready_i,
   output logic [31:0]               ex_instr_o,
   output logic [31:0]               ex_pc_o,
   output logic [DATA_W-1:0]         ex_rs_val_o,
   output logic [DATA_W-1:0]         ex_rt_val_o,
   output logic [31:0]               ex_link_o,
   output logic                      redirect_valid_o,
   output logic [31:0]               redirect_pc_o,
   input  logic                      flush_i,
   output logic [$clog2(DEPTH):0]    occupancy_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   ibuf_entry_t       mem_q [DEPTH];
   ibuf_entry_t       head;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic              ex_valid_q, redirect_valid_q;
   logic [31:0]       ex_instr_q, ex_pc_q, ex_link_q, redirect_pc_q;
   logic [DATA_W-1:0] ex_rs_val_q, ex_rt_val_q;
   logic [DATA_W:0]   res_a, res_b;
   logic              head_valid, interlock, ds_ok, issue, take, push_en;
   logic              br_is_ctrl, br_taken;
   logic [31:0]       br_target;

   // Returns {blocked, value}: lowest-index forwarding hit wins, then writeback, then RF.
   function automatic logic [DATA_W:0] resolve(
      input logic [4:0]                addr,
      input logic [DATA_W-1:0]         rf,
      input logic [NUM_FWD-1:0]        fv,
      input logic [NUM_FWD-1:0]        fr,
      input logic [NUM_FWD*5-1:0]      fa,
      input logic [NUM_FWD*DATA_W-1:0] fd,
      input logic                      we,
      input logic [4:0]                wa,
      input logic [DATA_W-1:0]         wd);
      logic [DATA_W:0] r;
      logic            hit;
      r   = {1'b0, rf};
      hit = 1'b0;
      if (addr == 5'd0) begin
         r = '0;
      end else begin
         for (int i = 0; i < NUM_FWD; i++) begin
            if (!hit && fv[i] && fa[i*5 +: 5] == addr) begin
               hit = 1'b1;
               r   = {!fr[i], fd[i*DATA_W +: DATA_W]};
            end
         end
         if (!hit && we && wa == addr)
            r = {1'b0, wd};
      end
      return r;
   endfunction

   assign head         = mem_q[rd_ptr_q];
   assign head_valid   = (count_q != '0);
   assign rf_raddr_a_o = head.instr[25:21];
   assign rf_raddr_b_o = head.instr[20:16];

   assign res_a = resolve(rf_raddr_a_o, rf_rdata_a_i, fwd_valid_i, fwd_ready_i, fwd_addr_i,
                          fwd_data_i, wb_we_i, wb_addr_i, wb_data_i);
   assign res_b = resolve(rf_raddr_b_o, rf_rdata_b_i, fwd_valid_i, fwd_ready_i, fwd_addr_i,
                          fwd_data_i, wb_we_i, wb_addr_i, wb_data_i);
   assign interlock = res_a[DATA_W] | res_b[DATA_W];

   id_branch_unit #(.DATA_W(DATA_W)) u_branch (
      .instr_i   (head.instr),
      .pc_i      (head.pc),
      .rs_val_i  (res_a[DATA_W-1:0]),
      .rt_val_i  (res_b[DATA_W-1:0]),
      .is_ctrl_o (br_is_ctrl),
      .taken_o   (br_taken),
      .target_o  (br_target)
   );

`ifdef ID_DELAY_SLOT_EN
   assign ds_ok = !(br_is_ctrl && br_taken) || (count_q > CW'(1));
`else
   assign ds_ok = 1'b1;
`endif

   assign if_ready_o = rst_ni && (count_q < DEPTH_C);
   assign issue      = head_valid && !interlock && ds_ok && (!ex_valid_q || ex_ready_i);
   assign take       = issue && br_is_ctrl && br_taken;
   // Beats arriving during the redirect pulse belong to the wrong path.
   assign push_en    = if_valid_i && if_ready_o && !redirect_valid_q;

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         rd_ptr_d = wr_ptr_q;
         count_d  = '0;
      end else if (take) begin
`ifdef ID_DELAY_SLOT_EN
         rd_ptr_d = rd_ptr_q + PW'(1);
         wr_ptr_d = rd_ptr_q + PW'(2);
         count_d  = CW'(1);
`else
         rd_ptr_d = wr_ptr_q;
         count_d  = '0;
`endif
      end else begin
         if (push_en) wr_ptr_d = wr_ptr_q + PW'(1);
         if (issue)   rd_ptr_d = rd_ptr_q + PW'(1);
         count_d = count_q + CW'(push_en) - CW'(issue);
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_en)
         mem_q[wr_ptr_q] <= {if_instr_i, if_pc_i};
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_ptr_q         <= '0;
         wr_ptr_q         <= '0;
         count_q          <= '0;
         ex_valid_q       <= 1'b0;
         ex_instr_q       <= '0;
         ex_pc_q          <= '0;
         ex_rs_val_q      <= '0;
         ex_rt_val_q      <= '0;
         ex_link_q        <= '0;
         redirect_valid_q <= 1'b0;
         redirect_pc_q    <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         if (flush_i) begin
            ex_valid_q       <= 1'b0;
            redirect_valid_q <= 1'b0;
         end else begin
            redirect_valid_q <= take;
            if (take) redirect_pc_q <= br_target;
            if (issue) begin
               ex_valid_q  <= 1'b1;
               ex_instr_q  <= head.instr;
               ex_pc_q     <= head.pc;
               ex_rs_val_q <= res_a[DATA_W-1:0];
               ex_rt_val_q <= res_b[DATA_W-1:0];
               ex_link_q   <= head.pc + 32'd8;
            end else if (ex_ready_i) begin
               ex_valid_q <= 1'b0;
            end
         end
      end
   end

   assign ex_valid_o       = ex_valid_q;
   assign ex_instr_o       = ex_instr_q;
   assign ex_pc_o          = ex_pc_q;
   assign ex_rs_val_o      = ex_rs_val_q;
   assign ex_rt_val_o      = ex_rt_val_q;
   assign ex_link_o        = ex_link_q;
   assign redirect_valid_o = redirect_valid_q;
   assign redirect_pc_o    = redirect_pc_q;
   assign occupancy_o      = count_q;

endmodule

// File: tb/tb_id_issue_buffer.sv
// tb/tb_id_issue_buffer.sv - directed vector bench for id_issue_buffer
module tb_id_issue_buffer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        if_valid, if_ready;
   logic [31:0] if_instr, if_pc;
   logic [4:0]  rf_raddr_a, rf_raddr_b;
   logic [31:0] rf_rdata_a, rf_rdata_b;
   logic        wb_we;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic [2:0]  fwd_valid, fwd_ready;
   logic [14:0] fwd_addr;
   logic [95:0] fwd_data;
   logic        ex_valid, ex_ready;
   logic [31:0] ex_instr, ex_pc, ex_rs_val, ex_rt_val, ex_link;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        flush;
   logic [2:0]  occupancy;

   int n_cmp;
   int n_err;

   typedef struct {
      logic [31:0] instr;
      logic [2:0]  fv;
      logic [14:0] fa;
      logic [95:0] fd;
      logic        we;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic [31:0] ers;
      logic [31:0] ert;
   } vec_t;

   vec_t vt [10];

   always #5 clk = ~clk;

   // Register-file model: distinct, recognisable values per port and address.
   assign rf_rdata_a = 32'h1000_0000 | {27'd0, rf_raddr_a};
   assign rf_rdata_b = 32'h2000_0000 | {27'd0, rf_raddr_b};

   id_issue_buffer #(.DATA_W(32), .DEPTH(4), .NUM_FWD(3)) dut (
      .clk_i            (clk),
      .rst_ni           (rst_n),
      .if_valid_i       (if_valid),
      .if_ready_o       (if_ready),
      .if_instr_i       (if_instr),
      .if_pc_i          (if_pc),
      .rf_raddr_a_o     (rf_raddr_a),
      .rf_raddr_b_o     (rf_raddr_b),
      .rf_rdata_a_i     (rf_rdata_a),
      .rf_rdata_b_i     (rf_rdata_b),
      .wb_we_i          (wb_we),
      .wb_addr_i        (wb_addr),
      .wb_data_i        (wb_data),
      .fwd_valid_i      (fwd_valid),
      .fwd_ready_i      (fwd_ready),
      .fwd_addr_i       (fwd_addr),
      .fwd_data_i       (fwd_data),
      .ex_valid_o       (ex_valid),
      .ex_ready_i       (ex_ready),
      .ex_instr_o       (ex_instr),
      .ex_pc_o          (ex_pc),
      .ex_rs_val_o      (ex_rs_val),
      .ex_rt_val_o      (ex_rt_val),
      .ex_link_o        (ex_link),
      .redirect_valid_o (redirect_valid),
      .redirect_pc_o    (redirect_pc),
      .flush_i          (flush),
      .occupancy_o      (occupancy)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] ins, input logic [31:0] pc);
      if_valid = 1'b1;
      if_instr = ins;
      if_pc    = pc;
      step();
   endtask

   task automatic clear_side();
      fwd_valid = 3'b000;
      fwd_ready = 3'b111;
      fwd_addr  = '0;
      fwd_data  = '0;
      wb_we     = 1'b0;
      wb_addr   = 5'd0;
      wb_data   = 32'd0;
   endtask

   function automatic logic [31:0] addu(input logic [4:0] rs, input logic [4:0] rt);
      return {6'h00, rs, rt, 5'd1, 5'd0, 6'h21};
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [31:0] pc;
      n_cmp = 0;
      n_err = 0;

      vt[0] = '{addu(5'd8, 5'd3), 3'b011, {5'd0, 5'd8, 5'd8}, {32'h0, 32'h22, 32'h11},
                1'b0, 5'd0, 32'h0, 32'h11, 32'h2000_0003};
      vt[1] = '{addu(5'd0, 5'd0), 3'b001, {5'd0, 5'd0, 5'd0}, {32'h0, 32'h0, 32'h55},
                1'b0, 5'd0, 32'h0, 32'h0, 32'h0};
      vt[2] = '{addu(5'd8, 5'd3), 3'b110, {5'd3, 5'd8, 5'd0}, {32'h33, 32'h22, 32'h0},
                1'b0, 5'd0, 32'h0, 32'h22, 32'h33};
      vt[3] = '{addu(5'd5, 5'd6), 3'b000, 15'd0, 96'd0,
                1'b1, 5'd5, 32'h5555, 32'h5555, 32'h2000_0006};
      vt[4] = '{addu(5'd5, 5'd6), 3'b100, {5'd5, 5'd0, 5'd0}, {32'h77, 32'h0, 32'h0},
                1'b1, 5'd5, 32'h5555, 32'h77, 32'h2000_0006};
      vt[5] = '{addu(5'd7, 5'd9), 3'b000, 15'd0, 96'd0,
                1'b0, 5'd0, 32'h0, 32'h1000_0007, 32'h2000_0009};
      vt[6] = '{addu(5'd7, 5'd9), 3'b000, {5'd9, 5'd7, 5'd7}, {32'hA, 32'hB, 32'hC},
                1'b0, 5'd0, 32'h0, 32'h1000_0007, 32'h2000_0009};
      vt[7] = '{{6'h05, 5'd0, 5'd0, 16'h0008}, 3'b000, 15'd0, 96'd0,
                1'b0, 5'd0, 32'h0, 32'h0, 32'h0};
      vt[8] = '{{6'h01, 5'd4, 5'd1, 16'h0010}, 3'b001, {5'd0, 5'd0, 5'd4}, {32'h0, 32'h0, 32'h8000_0000},
                1'b0, 5'd0, 32'h0, 32'h8000_0000, 32'h2000_0001};
      vt[9] = '{{6'h01, 5'd4, 5'd0, 16'h0010}, 3'b000, 15'd0, 96'd0,
                1'b0, 5'd0, 32'h0, 32'h1000_0004, 32'h0};

      rst_n    = 1'b0;
      if_valid = 1'b0;
      if_instr = 32'd0;
      if_pc    = 32'd0;
      ex_ready = 1'b0;
      flush    = 1'b0;
      clear_side();
      #12;
      chk("rst_if_ready", 32'(if_ready), 32'd0);
      chk("rst_ex_valid", 32'(ex_valid), 32'd0);
      chk("rst_redirect_valid", 32'(redirect_valid), 32'd0);
      chk("rst_redirect_pc", redirect_pc, 32'd0);
      chk("rst_ex_pc", ex_pc, 32'd0);
      chk("rst_occupancy", 32'(occupancy), 32'd0);
      step();
      rst_n = 1'b1;
      #1;
      chk("post_rst_if_ready", 32'(if_ready), 32'd1);
      ex_ready = 1'b1;

      for (int k = 0; k < 10; k++) begin
         fwd_valid = vt[k].fv;
         fwd_ready = 3'b111;
         fwd_addr  = vt[k].fa;
         fwd_data  = vt[k].fd;
         wb_we     = vt[k].we;
         wb_addr   = vt[k].wa;
         wb_data   = vt[k].wd;
         pc = 32'h1000 + 32'(k) * 32'd16;
         push(vt[k].instr, pc);
         if_valid = 1'b0;
         step();
         chk($sformatf("vec%0d_ex_valid", k), 32'(ex_valid), 32'd1);
         chk($sformatf("vec%0d_ex_rs_val", k), ex_rs_val, vt[k].ers);
         chk($sformatf("vec%0d_ex_rt_val", k), ex_rt_val, vt[k].ert);
         chk($sformatf("vec%0d_ex_link", k), ex_link, pc + 32'd8);
         chk($sformatf("vec%0d_ex_instr", k), ex_instr, vt[k].instr);
         chk($sformatf("vec%0d_redirect", k), 32'(redirect_valid), 32'd0);
         clear_side();
      end

      // Fill to full with the consumer stalled, then drain in order.
      step();
      step();
      ex_ready = 1'b0;
      for (int b = 0; b < 5; b++) push(addu(5'd1, 5'd2), 32'h200 + 32'(b) * 32'd4);
      chk("full_occupancy", 32'(occupancy), 32'd4);
      chk("full_if_ready", 32'(if_ready), 32'd0);
      chk("full_ex_valid", 32'(ex_valid), 32'd1);
      chk("full_ex_pc", ex_pc, 32'h200);
      if_pc    = 32'h214;
      ex_ready = 1'b1;
      step();
      chk("full_push_refused_occ", 32'(occupancy), 32'd3);
      chk("drain_pc1", ex_pc, 32'h204);
      if_valid = 1'b0;
      for (int j = 2; j < 5; j++) begin
         step();
         chk($sformatf("drain_pc%0d", j), ex_pc, 32'h200 + 32'(j) * 32'd4);
         chk($sformatf("drain_occ%0d", j), 32'(occupancy), 32'(4 - j));
      end
      step();
      chk("drain_done_ex_valid", 32'(ex_valid), 32'd0);

      // Load-use interlock on rs=9.
      fwd_valid = 3'b001;
      fwd_ready = 3'b000;
      fwd_addr  = {10'd0, 5'd9};
      fwd_data  = 96'd0;
      push({6'h23, 5'd9, 5'd10, 16'h0004}, 32'h400);
      if_valid = 1'b0;
      chk("lw_raddr_a", 32'(rf_raddr_a), 32'd9);
      chk("lw_raddr_b", 32'(rf_raddr_b), 32'd10);
      for (int c = 0; c < 3; c++) begin
         step();
         chk($sformatf("lw_blocked_c%0d", c), 32'(ex_valid), 32'd0);
      end
      fwd_ready = 3'b001;
      fwd_data  = {64'd0, 32'hDEAD};
      step();
      chk("lw_release_ex_valid", 32'(ex_valid), 32'd1);
      chk("lw_release_rs", ex_rs_val, 32'hDEAD);
      chk("lw_release_rt", ex_rt_val, 32'h2000_000A);
      chk("lw_release_pc", ex_pc, 32'h400);
      clear_side();
      step();

      // JR through the writeback bypass.
      wb_we   = 1'b1;
      wb_addr = 5'd31;
      wb_data = 32'h8000_0040;
      push({6'h00, 5'd31, 15'd0, 6'h08}, 32'h300);
      push(addu(5'd0, 5'd0), 32'h304);
      if_valid = 1'b0;
`ifdef ID_DELAY_SLOT_EN
      step();
`endif
      chk("jr_ex_valid", 32'(ex_valid), 32'd1);
      chk("jr_ex_pc", ex_pc, 32'h300);
      chk("jr_redirect_valid", 32'(redirect_valid), 32'd1);
      chk("jr_redirect_pc", redirect_pc, 32'h8000_0040);
      chk("jr_ex_rs_val", ex_rs_val, 32'h8000_0040);
      chk("jr_ex_link", ex_link, 32'h308);
      step();
      chk("jr_redirect_pulse_end", 32'(redirect_valid), 32'd0);
`ifdef ID_DELAY_SLOT_EN
      chk("jr_delay_slot_valid", 32'(ex_valid), 32'd1);
      chk("jr_delay_slot_pc", ex_pc, 32'h304);
`else
      chk("jr_younger_dropped", 32'(ex_valid), 32'd0);
`endif
      clear_side();
      step();

      // BEQ $0,$0,+4 at 0x100 -> target 0x114.
      push({6'h04, 5'd0, 5'd0, 16'h0004}, 32'h100);
      chk("beq_e1_occ", 32'(occupancy), 32'd1);
      chk("beq_e1_ex_valid", 32'(ex_valid), 32'd0);
      push(addu(5'd1, 5'd2), 32'h104);
`ifdef ID_DELAY_SLOT_EN
      chk("beq_e2_ex_valid", 32'(ex_valid), 32'd0);
      chk("beq_e2_occ", 32'(occupancy), 32'd2);
      push(addu(5'd1, 5'd2), 32'h108);
      if_valid = 1'b0;
      chk("beq_issue_ex_pc", ex_pc, 32'h100);
      chk("beq_issue_redirect_valid", 32'(redirect_valid), 32'd1);
      chk("beq_issue_redirect_pc", redirect_pc, 32'h114);
      chk("beq_issue_occ", 32'(occupancy), 32'd1);
      step();
      chk("beq_ds_ex_valid", 32'(ex_valid), 32'd1);
      chk("beq_ds_ex_pc", ex_pc, 32'h104);
      chk("beq_ds_redirect_valid", 32'(redirect_valid), 32'd0);
      chk("beq_ds_occ", 32'(occupancy), 32'd0);
      step();
      chk("beq_108_dropped", 32'(ex_valid), 32'd0);
`else
      chk("beq_issue_ex_valid", 32'(ex_valid), 32'd1);
      chk("beq_issue_ex_pc", ex_pc, 32'h100);
      chk("beq_issue_redirect_valid", 32'(redirect_valid), 32'd1);
      chk("beq_issue_redirect_pc", redirect_pc, 32'h114);
      chk("beq_issue_occ", 32'(occupancy), 32'd0);
      push(addu(5'd1, 5'd2), 32'h108);
      if_valid = 1'b0;
      chk("beq_e3_redirect_valid", 32'(redirect_valid), 32'd0);
      chk("beq_e3_ex_valid", 32'(ex_valid), 32'd0);
      chk("beq_e3_occ", 32'(occupancy), 32'd0);
      step();
      chk("beq_104_dropped", 32'(ex_valid), 32'd0);
      chk("beq_e4_occ", 32'(occupancy), 32'd0);
`endif
      step();

      // Flush with three buffered and one in EX.
      ex_ready = 1'b0;
      for (int b = 0; b < 4; b++) push(addu(5'd1, 5'd2), 32'h500 + 32'(b) * 32'd4);
      chk("pre_flush_occ", 32'(occupancy), 32'd3);
      chk("pre_flush_ex_valid", 32'(ex_valid), 32'd1);
      if_pc = 32'h510;
      flush = 1'b1;
      step();
      flush    = 1'b0;
      if_valid = 1'b0;
      chk("flush_occ", 32'(occupancy), 32'd0);
      chk("flush_ex_valid", 32'(ex_valid), 32'd0);
      chk("flush_redirect_valid", 32'(redirect_valid), 32'd0);
      chk("flush_if_ready", 32'(if_ready), 32'd1);
      ex_ready = 1'b1;
      push(addu(5'd1, 5'd2), 32'h600);
      if_valid = 1'b0;
      step();
      chk("post_flush_ex_valid", 32'(ex_valid), 32'd1);
      chk("post_flush_ex_pc", ex_pc, 32'h600);

      // Asynchronous reset between clock edges.
      ex_ready = 1'b0;
      push(addu(5'd1, 5'd2), 32'h700);
      push(addu(5'd1, 5'd2), 32'h704);
      if_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_occ", 32'(occupancy), 32'd0);
      chk("arst_ex_valid", 32'(ex_valid), 32'd0);
      chk("arst_if_ready", 32'(if_ready), 32'd0);
      chk("arst_ex_pc", ex_pc, 32'd0);
      chk("arst_ex_rs_val", ex_rs_val, 32'd0);
      chk("arst_redirect_pc", redirect_pc, 32'd0);
      chk("arst_redirect_valid", 32'(redirect_valid), 32'd0);
      step();
      rst_n = 1'b1;
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
